// File: rtl/tone_pkg.sv
// Shared constants for the tone synthesiser: key codes, octave-0 half-period table, FSM states.
package tone_pkg;

    localparam int unsigned BASE_W    = 13;
    localparam int unsigned NUM_TONES = 12;

    localparam logic [3:0] KEY_STAR    = 4'd10;
    localparam logic [3:0] KEY_HASH    = 4'd11;
    localparam logic [3:0] KEY_OFF_MIN = 4'd12;

    // Indexed by key code 0..11; entry 0 is digit 0, which sits above '*' in pitch.
    localparam logic [BASE_W-1:0] BASE_TABLE [NUM_TONES] = '{
        13'd2863, 13'd7645, 13'd6810, 13'd6067,
        13'd5727, 13'd5102, 13'd4545, 13'd4050,
        13'd3822, 13'd3405, 13'd3034, 13'd2551
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

endpackage

// File: rtl/tone_period_lut.sv
// Combinational map from (key, octave) to the rounded half-period count and a stop flag.
module tone_period_lut
    import tone_pkg::*;
#(
    parameter int unsigned NUM_OCT = 3,
    parameter int unsigned CNT_W   = 13,
    parameter int unsigned OCT_W   = 2
) (
    input  logic [3:0]       key_i,
    input  logic [OCT_W-1:0] octave_i,
    output logic [CNT_W-1:0] half_c,
    output logic             stop_c
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] base_c;
    logic [SUM_W-1:0] round_c;
    logic [SUM_W-1:0] sum_c;

    // Octave n divides by 2^n with round-half-up; (1<<n)>>1 is 0 for n=0, 2^(n-1) otherwise.
    always_comb begin
        base_c = '0;
        if (key_i <= KEY_HASH) begin
            base_c = SUM_W'(BASE_TABLE[key_i]);
        end
        round_c = (SUM_W'(1) << octave_i) >> 1;
        sum_c   = base_c + round_c;
        half_c  = CNT_W'(sum_c >> octave_i);
        stop_c  = (key_i >= KEY_OFF_MIN) || (32'(octave_i) >= NUM_OCT);
    end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator; tone changes and stops take effect only at a half-period boundary.
module tone_synth
    import tone_pkg::*;
#(
    parameter int unsigned NUM_OCT = 3,
    parameter int unsigned CNT_W   = 13,
    parameter int unsigned OCT_W   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [3:0]       key,
    input  logic             key_valid,
    input  logic [OCT_W-1:0] octave,
    output logic             D_out,
    output logic             active
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] pend_half_q;
    logic             pend_stop_q;
    logic             d_out_q;
    logic             active_q;

    logic [CNT_W-1:0] lut_half_c;
    logic             lut_stop_c;
    logic             wrap_c;

    tone_period_lut #(
        .NUM_OCT (NUM_OCT),
        .CNT_W   (CNT_W),
        .OCT_W   (OCT_W)
    ) u_lut (
        .key_i    (key),
        .octave_i (octave),
        .half_c   (lut_half_c),
        .stop_c   (lut_stop_c)
    );

    assign wrap_c = (cnt_q == period_q - CNT_W'(1));
    assign D_out  = d_out_q;
    assign active = active_q;

    // A request seen on a wrap cycle is only latched as pending, so it lands one wrap later.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            pend_half_q <= '0;
            pend_stop_q <= 1'b0;
            d_out_q     <= 1'b0;
            active_q    <= 1'b0;
        end else if (EN) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_valid && !lut_stop_c) begin
                        state_q  <= ST_PLAY;
                        period_q <= lut_half_c;
                        cnt_q    <= '0;
                        d_out_q  <= 1'b1;
                        active_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (wrap_c) begin
                        cnt_q   <= '0;
                        d_out_q <= ~d_out_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (key_valid) begin
                        pend_half_q <= lut_half_c;
                        pend_stop_q <= lut_stop_c;
                        state_q     <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    if (wrap_c) begin
                        cnt_q <= '0;
                        if (pend_stop_q) begin
                            state_q     <= ST_IDLE;
                            d_out_q     <= 1'b0;
                            active_q    <= 1'b0;
                            pend_stop_q <= 1'b0;
                        end else begin
                            period_q <= pend_half_q;
                            d_out_q  <= ~d_out_q;
                            if (key_valid) begin
                                pend_half_q <= lut_half_c;
                                pend_stop_q <= lut_stop_c;
                            end else begin
                                state_q <= ST_PLAY;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (key_valid) begin
                            pend_half_q <= lut_half_c;
                            pend_stop_q <= lut_stop_c;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    d_out_q  <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed and randomized checks of tone_synth against a phase-countdown reference model.
module tb_tone_synth;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] key = 4'd0;
    logic       kv  = 1'b0;
    logic [1:0] oct = 2'd0;
    logic       d_out;
    logic       active;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: tone level, cycles left in the current phase, one pending request.
    bit m_play = 0;
    bit m_lvl  = 0;
    int m_half = 0;
    int m_left = 0;
    bit m_has  = 0;
    int m_phalf = 0;
    bit m_pstop = 0;

    // Phase measurement from the observed output.
    logic prev_d = 1'b0;
    int   since = 0;
    int   last_phase = 0;
    bit   toggled = 0;

    int base_tab [12] = '{2863, 7645, 6810, 6067, 5727, 5102, 4545, 4050, 3822, 3405, 3034, 2551};

    tone_synth #(.NUM_OCT(3), .CNT_W(13), .OCT_W(2)) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .key       (key),
        .key_valid (kv),
        .octave    (oct),
        .D_out     (d_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    function automatic bit ref_stop(input int k, input int o);
        return (k >= 12) || (o >= 3);
    endfunction

    function automatic int ref_half(input int k, input int o);
        int b;
        if (k >= 12) return 0;
        b = base_tab[k];
        if (o == 0) return b;
        return (b + (1 << (o - 1))) / (1 << o);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic v,
                              input int k, input int o);
        int h;
        bit st;
        bit had;
        int ph;
        bit ps;
        h  = ref_half(k, o);
        st = ref_stop(k, o);
        if (!r) begin
            m_play = 0; m_lvl = 0; m_has = 0; m_left = 0; m_half = 0;
        end else if (e) begin
            if (!m_play) begin
                if (v && !st) begin
                    m_play = 1; m_lvl = 1; m_half = h; m_left = h;
                end
            end else begin
                had = m_has; ph = m_phalf; ps = m_pstop;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (had && ps) begin
                        m_play = 0; m_lvl = 0; m_has = 0;
                    end else begin
                        if (had) m_half = ph;
                        m_has  = 0;
                        m_lvl  = !m_lvl;
                        m_left = m_half;
                    end
                end
                if (v && m_play) begin
                    m_has = 1; m_phalf = h; m_pstop = st;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, en, kv, int'(key), int'(oct));
        #1;
        chk("d_out", {31'b0, d_out}, {31'b0, m_lvl});
        chk("active", {31'b0, active}, {31'b0, m_play});
        since++;
        if (d_out !== prev_d) begin
            last_phase = since;
            since = 0;
            toggled = 1;
        end
        prev_d = d_out;
    endtask

    task automatic req(input int k, input int o);
        key = 4'(k);
        oct = 2'(o);
        kv  = 1'b1;
        tick();
        kv  = 1'b0;
    endtask

    task automatic wait_toggle(output int ph);
        int n;
        n = 0;
        while (!toggled && n < 20000) begin
            tick();
            n++;
        end
        chk("toggle_timeout", {31'b0, toggled}, 32'd1);
        toggled = 0;
        ph = last_phase;
    endtask

    initial begin
        int ph;
        int nt;

        // Reset state
        repeat (3) tick();
        chk("reset_dout", {31'b0, d_out}, 32'd0);
        chk("reset_active", {31'b0, active}, 32'd0);
        rst = 1'b1;
        tick();

        // Stop requests from IDLE are ignored
        req(3, 3);
        req(15, 0);
        repeat (5) tick();
        chk("idle_stays_idle", {31'b0, active}, 32'd0);

        // Key 1, octave 0
        req(1, 0);
        chk("start_dout", {31'b0, d_out}, 32'd1);
        chk("start_active", {31'b0, active}, 32'd1);
        toggled = 0;
        wait_toggle(ph); chk("k1_phase_a", ph, 7645);
        wait_toggle(ph); chk("k1_phase_b", ph, 7645);

        // Mid-phase switch to key 5
        repeat (1000) tick();
        req(5, 0);
        wait_toggle(ph); chk("switch_old_completes", ph, 7645);
        wait_toggle(ph); chk("switch_new_5102", ph, 5102);

        // Key 8 octave 1: half 1911, period 3822
        req(8, 1);
        wait_toggle(ph); chk("k5_before_k8", ph, 5102);
        wait_toggle(ph); chk("k8o1_high", ph, 1911);
        wait_toggle(ph); chk("k8o1_low", ph, 1911);

        // Two requests before a wrap: last wins
        req(3, 0);
        repeat (10) tick();
        req(8, 2);
        wait_toggle(ph); chk("lastwin_old", ph, 1911);
        wait_toggle(ph); chk("lastwin_k8o2", ph, 956);
        wait_toggle(ph); chk("lastwin_k8o2_b", ph, 956);

        // EN low for 100 cycles with an ignored request
        repeat (200) tick();
        en = 1'b0;
        key = 4'd1; oct = 2'd0; kv = 1'b1;
        repeat (100) tick();
        kv = 1'b0;
        en = 1'b1;
        wait_toggle(ph); chk("en_freeze_late", ph, 1056);
        wait_toggle(ph); chk("en_req_ignored", ph, 956);
        chk("en_still_active", {31'b0, active}, 32'd1);

        // Request landing exactly on the wrap cycle
        repeat (955) tick();
        req(4, 0);
        wait_toggle(ph); chk("wrapreq_wrap", ph, 956);
        wait_toggle(ph); chk("wrapreq_deferred", ph, 956);
        wait_toggle(ph); chk("wrapreq_applied", ph, 5727);

        // Stop via key 15, taken at the next wrap
        if (d_out === 1'b0) begin
            wait_toggle(ph); chk("pre_stop_phase", ph, 5727);
        end
        repeat (100) tick();
        req(15, 0);
        wait_toggle(ph); chk("stop_phase", ph, 5727);
        chk("stop_dout", {31'b0, d_out}, 32'd0);
        chk("stop_active", {31'b0, active}, 32'd0);

        // Reset mid-tone
        req(1, 0);
        repeat (50) tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_dout", {31'b0, d_out}, 32'd0);
        chk("rst_mid_active", {31'b0, active}, 32'd0);
        rst = 1'b1;
        toggled = 0;
        repeat (3000) tick();
        chk("rst_no_toggle", {31'b0, toggled}, 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 30; i++) begin
            en = ($urandom_range(0, 7) != 0);
            nt = $urandom_range(1, 600);
            repeat (nt) tick();
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            req($urandom_range(0, 15), $urandom_range(0, 3));
        end
        en = 1'b1;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
